pc_unit: RTL

Parametrised program-counter block for the single-cycle datapath, superseding the plain 32-bit load register. It holds the current fetch address and advances it by a fixed step each enabled cycle. It also supports absolute loads, PC-relative branches and stalls. A small return-address stack (RAS) handles call/return pairs, with full, empty and sticky-error status.

---
 rtl/pc_unit.sv | 132 +++++++++++++
 1 files changed

// File: rtl/pc_unit.sv
// Program counter with sequential advance, absolute load, PC-relative
// branch, stall, and a circular return-address stack for call/return.
// Operation priority when enabled: ret > call > load > branch > step.
module pc_unit #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_PC  = '0,
   parameter int               STEP      = 4,
   parameter int               RAS_DEPTH = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               en,
   input  logic                               l,
   input  logic [WIDTH-1:0]                   r,
   input  logic                               br,
   input  logic [WIDTH-1:0]                   off,
   input  logic                               call,
   input  logic                               ret,
   output logic [WIDTH-1:0]                   q,
   output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_cnt,
   output logic                               ras_full,
   output logic                               ras_empty,
   output logic                               err
);

   localparam int CW = $clog2(RAS_DEPTH + 1);
   localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

   localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
   localparam logic [CW-1:0]    DEPTH_C  = CW'(RAS_DEPTH);
   localparam logic [PW-1:0]    PTR_LAST = PW'(RAS_DEPTH - 1);

   typedef enum logic [2:0] {
      OP_HOLD,
      OP_RET,
      OP_CALL,
      OP_LOAD,
      OP_BRANCH,
      OP_STEP
   } op_t;

   op_t              op;
   logic [WIDTH-1:0] q_nxt;
   logic [WIDTH-1:0] q_inc;
   logic [PW-1:0]    ptr;
   logic [PW-1:0]    ptr_nxt;
   logic [PW-1:0]    ptr_inc;
   logic [PW-1:0]    ptr_dec;
   logic [CW-1:0]    cnt_nxt;
   logic             err_nxt;
   logic             push;
   logic [WIDTH-1:0] stack [RAS_DEPTH];

   assign q_inc     = q + STEP_W;
   assign ras_full  = (ras_cnt == DEPTH_C);
   assign ras_empty = (ras_cnt == '0);

   // Pointer neighbours, wrapping modulo RAS_DEPTH (depth need not be a power of two)
   always_comb begin
      ptr_inc = (ptr == PTR_LAST) ? '0 : ptr + PW'(1);
      ptr_dec = (ptr == '0) ? PTR_LAST : ptr - PW'(1);
   end

   // Priority decode of the requested operation; a stall overrides everything
   always_comb begin
      op = OP_HOLD;
      if (en) begin
         if (ret)       op = OP_RET;
         else if (call) op = OP_CALL;
         else if (l)    op = OP_LOAD;
         else if (br)   op = OP_BRANCH;
         else           op = OP_STEP;
      end
   end

   // Next-state computation for PC, stack pointer, occupancy and sticky error
   always_comb begin
      q_nxt   = q;
      ptr_nxt = ptr;
      cnt_nxt = ras_cnt;
      err_nxt = err;
      push    = 1'b0;
      case (op)
         OP_RET: begin
            if (!ras_empty) begin
               q_nxt   = stack[ptr];
               ptr_nxt = ptr_dec;
               cnt_nxt = ras_cnt - CW'(1);
            end else begin
               // underflow: behave like a plain step and flag it
               q_nxt   = q_inc;
               err_nxt = 1'b1;
            end
            // a simultaneous call is dropped, which is itself an error
            if (call) err_nxt = 1'b1;
         end
         OP_CALL: begin
            push    = 1'b1;
            q_nxt   = r;
            ptr_nxt = ptr_inc;
            // when full, the push lands on the oldest entry and count saturates
            if (ras_full) err_nxt = 1'b1;
            else          cnt_nxt = ras_cnt + CW'(1);
         end
         OP_LOAD:   q_nxt = r;
         OP_BRANCH: q_nxt = q + off;
         OP_STEP:   q_nxt = q_inc;
         default:   q_nxt = q;
      endcase
   end

   // Control registers, asynchronously returned to their reset values
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q       <= RESET_PC;
         ptr     <= '0;
         ras_cnt <= '0;
         err     <= 1'b0;
      end else begin
         q       <= q_nxt;
         ptr     <= ptr_nxt;
         ras_cnt <= cnt_nxt;
         err     <= err_nxt;
      end
   end

   // Stack storage; contents are never read while empty, so no reset is needed
   always_ff @(posedge clk) begin
      if (push) stack[ptr_inc] <= q_inc;
   end

endmodule
